// File: rtl/leiwand_rv32_wb_intercon.sv
// Single-master, N-slave pipelined Wishbone interconnect with parametric decode windows.
// One request outstanding; only the selected slave's ack/data reach the master, unmapped or silent slaves end in a bus error.
module leiwand_rv32_wb_intercon #(
  parameter int                              MEM_WIDTH      = 32,
  parameter int                              NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_BASE     = {32'h4000_0000, 32'h3000_0000,
                                                               32'h2000_0000, 32'h1000_0000},
  parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_SIZE     = {4{32'd512}},
  parameter int                              TIMEOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wb_stb,
  input  logic                            wb_cyc,
  input  logic                            wb_we,
  input  logic [MEM_WIDTH-1:0]            wb_addr,
  input  logic [MEM_WIDTH-1:0]            wb_data_out,
  output logic                            wb_ack,
  output logic                            wb_err,
  output logic                            wb_stall,
  output logic [MEM_WIDTH-1:0]            wb_data_in,
  output logic [NUM_SLAVES-1:0]           s_stb,
  output logic                            s_cyc,
  output logic                            s_we,
  output logic [MEM_WIDTH-1:0]            s_addr,
  output logic [MEM_WIDTH-1:0]            s_data_out,
  input  logic [NUM_SLAVES-1:0]           s_ack,
  input  logic [NUM_SLAVES-1:0]           s_stall,
  input  logic [NUM_SLAVES*MEM_WIDTH-1:0] s_data_in,
  output logic [15:0]                     err_count
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR
  } state_t;

  state_t                 state_q;
  logic [SEL_W-1:0]       sel_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [15:0]            err_count_q;
  logic [15:0]            err_count_d;

  logic                   req;
  logic [NUM_SLAVES-1:0]  in_win;
  logic                   hit_any;
  logic [SEL_W-1:0]       hit_idx;
  logic [MEM_WIDTH-1:0]   hit_base;
  logic                   ack_sel;
  logic                   timeout;

  assign req = wb_cyc && wb_stb;

  // Window end computed one bit wider so a window touching the top of the map cannot wrap.
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_win
    logic [MEM_WIDTH:0] lo;
    logic [MEM_WIDTH:0] hi;
    assign lo        = {1'b0, SLAVE_BASE[g*MEM_WIDTH +: MEM_WIDTH]};
    assign hi        = lo + {1'b0, SLAVE_SIZE[g*MEM_WIDTH +: MEM_WIDTH]};
    assign in_win[g] = ({1'b0, wb_addr} >= lo) && ({1'b0, wb_addr} < hi);
  end

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (in_win[k]) begin
        hit_any = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  assign hit_base   = SLAVE_BASE[hit_idx*MEM_WIDTH +: MEM_WIDTH];
  assign s_addr     = wb_addr - hit_base;
  assign s_cyc      = wb_cyc;
  assign s_we       = wb_we;
  assign s_data_out = wb_data_out;

  assign ack_sel = s_ack[sel_q];
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // A dropped wb_cyc suppresses both terminations in the aborting cycle.
  always_comb begin
    s_stb      = '0;
    wb_stall   = 1'b0;
    wb_ack     = 1'b0;
    wb_err     = 1'b0;
    wb_data_in = '0;
    case (state_q)
      ST_IDLE: begin
        if (req && hit_any) begin
          s_stb[hit_idx] = 1'b1;
          wb_stall       = s_stall[hit_idx];
        end
      end
      ST_WAIT: begin
        wb_stall = 1'b1;
        if (wb_cyc) begin
          wb_ack = ack_sel;
          wb_err = !ack_sel && timeout;
          if (ack_sel) wb_data_in = s_data_in[sel_q*MEM_WIDTH +: MEM_WIDTH];
        end
      end
      ST_ERR: begin
        wb_stall = 1'b1;
        wb_err   = wb_cyc;
      end
      default: ;
    endcase
  end

  assign err_count_d = (wb_err && (err_count_q != 16'hFFFF)) ? err_count_q + 16'd1 : err_count_q;
  assign err_count   = err_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (!hit_any) begin
              state_q <= ST_ERR;
            end else if (!s_stall[hit_idx]) begin
              sel_q   <= hit_idx;
              cnt_q   <= '0;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!wb_cyc || ack_sel || timeout) state_q <= ST_IDLE;
          else                               cnt_q   <= cnt_q + CNT_W'(1);
        end
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_wb_intercon.sv
// Randomised bench for the Wishbone interconnect against a transaction-level model of decode, latency and error rules.
module tb_leiwand_rv32_wb_intercon;

  localparam int MW = 32;
  localparam int NS = 4;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             wb_stb, wb_cyc, wb_we;
  logic [MW-1:0]    wb_addr, wb_data_out;
  logic             wb_ack, wb_err, wb_stall;
  logic [MW-1:0]    wb_data_in;
  logic [NS-1:0]    s_stb;
  logic             s_cyc, s_we;
  logic [MW-1:0]    s_addr, s_data_out;
  logic [NS-1:0]    s_ack, s_stall;
  logic [NS*MW-1:0] s_data_in;
  logic [15:0]      err_count;

  leiwand_rv32_wb_intercon #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data_out(wb_data_out),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall), .wb_data_in(wb_data_in),
    .s_stb(s_stb), .s_cyc(s_cyc), .s_we(s_we), .s_addr(s_addr), .s_data_out(s_data_out),
    .s_ack(s_ack), .s_stall(s_stall), .s_data_in(s_data_in),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_errs = 0;

  logic [31:0] win_base [NS] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
  longint unsigned win_size = 512;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First window containing the address, or -1 when unmapped.
  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++) begin
      if (longint'(a) >= longint'(win_base[k]) && longint'(a) < longint'(win_base[k]) + longint'(win_size))
        return k;
    end
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_slaves();
    s_stall = NS'($urandom);
    for (int k = 0; k < NS; k++) s_data_in[k*MW +: MW] = $urandom;
  endtask

  // d: ack cycle after accept (0 = never), abort_at: cycle wb_cyc drops (0 = never).
  task automatic do_txn(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int nstall, input int d,
                        input int abort_at, input bit spurious, input bit gap);
    int            k;
    int            nreq;
    logic [NS-1:0] exp_stb;
    bit            done, aborted, exp_ack, exp_err;
    k       = decode(addr);
    exp_stb = (k >= 0) ? (NS'(1) << k) : '0;
    nreq    = (k >= 0) ? nstall : 0;
    for (int c = 0; c <= nreq; c++) begin
      next_cycle();
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_data_out = wdata;
      randomize_slaves();
      s_ack = NS'($urandom);
      if (k >= 0) s_stall[k] = (c < nstall);
      @(negedge clk);
      check("req_stb", s_stb, exp_stb);
      check("req_stall", wb_stall, (k >= 0) && (c < nstall));
      check("req_ack_err", {wb_ack, wb_err}, 2'b00);
      check("req_pass", {s_cyc, s_we, s_data_out}, {1'b1, we, wdata});
      check("req_errcnt", err_count, exp_errs);
      if (k >= 0) check("req_s_addr", s_addr, addr - win_base[k]);
    end
    next_cycle();
    wb_stb = 1'b0;
    if (k < 0) begin
      randomize_slaves();
      s_ack = NS'($urandom);
      @(negedge clk);
      check("unmap_err", {wb_ack, wb_err, wb_stall}, 3'b011);
      check("unmap_stb", s_stb, 0);
      exp_errs++;
    end else begin
      done = 1'b0;
      for (int i = 1; i <= TO && !done; i++) begin
        if (i > 1) next_cycle();
        randomize_slaves();
        s_ack = spurious ? '1 : '0;
        s_ack[k] = (i == d);
        if (i == d) s_data_in[k*MW +: MW] = rdata;
        aborted = (i == abort_at);
        if (aborted) begin
          wb_cyc   = 1'b0;
          s_ack[k] = 1'b1;
        end
        exp_ack = !aborted && (i == d);
        exp_err = !aborted && (i == TO) && (i != d);
        @(negedge clk);
        check("wait_ack", wb_ack, exp_ack);
        check("wait_err", wb_err, exp_err);
        check("wait_data", wb_data_in, exp_ack ? rdata : 32'h0);
        check("wait_stall_stb", {wb_stall, s_stb}, {1'b1, {NS{1'b0}}});
        if (exp_err) exp_errs++;
        done = aborted || exp_ack || exp_err;
      end
    end
    if (gap) begin
      next_cycle();
      wb_cyc = 1'b0; wb_stb = 1'b0;
      randomize_slaves();
      s_ack = NS'($urandom);
      @(negedge clk);
      check("idle_out", {wb_ack, wb_err, wb_stall, s_stb}, 0);
      check("idle_errcnt", err_count, exp_errs);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          r;
    reset = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b0; wb_we = 1'b0;
    wb_addr = '0; wb_data_out = '0; s_ack = '1; s_stall = '0; s_data_in = '0;
    #12;
    check("rst_out", {wb_ack, wb_err, wb_stall}, 3'b000);
    check("rst_errcnt", err_count, 0);
    check("rst_s_cyc", s_cyc, 1'b1);
    wb_cyc = 1'b0;
    #1;
    check("rst_s_cyc_follow", s_cyc, 1'b0);
    next_cycle();
    reset = 1'b1; s_ack = '0;

    do_txn(32'h1000_0008, 1'b0, 32'h0, 32'h4A, 0, 1, 0, 1'b0, 1'b1);
    do_txn(32'h2000_0004, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 3, 1, 0, 1'b1, 1'b1);
    do_txn(32'h5000_0000, 1'b0, 32'h0, 32'h0, 0, 0, 0, 1'b0, 1'b1);
    do_txn(32'h3000_0000, 1'b0, 32'h0, 32'h0, 0, 0, 0, 1'b0, 1'b1);
    do_txn(32'h3000_0010, 1'b0, 32'h0, 32'hCAFE_0016, 0, TO, 0, 1'b0, 1'b1);
    do_txn(32'h1000_0020, 1'b0, 32'h0, 32'h0000_0A0A, 0, 4, 0, 1'b1, 1'b1);
    do_txn(32'h1000_01FC, 1'b0, 32'h0, 32'h0000_01FC, 0, 2, 0, 1'b0, 1'b0);
    do_txn(32'h1000_0200, 1'b0, 32'h0, 32'h0, 0, 0, 0, 1'b0, 1'b1);
    do_txn(32'h4000_0100, 1'b1, 32'h5555_AAAA, 32'h0, 0, 8, 3, 1'b0, 1'b1);

    // Reset while waiting on slave 1, with its ack arriving in the same cycle.
    do_txn(32'h2000_0010, 1'b0, 32'h0, 32'h0, 0, 0, 3, 1'b0, 1'b1);
    next_cycle();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_addr = 32'h2000_0010; s_stall = '0; s_ack = '0;
    next_cycle();
    wb_stb = 1'b0;
    next_cycle();
    @(negedge clk);
    check("rst_mid_stall", wb_stall, 1'b1);
    next_cycle();
    s_ack = 4'b0010; reset = 1'b0;
    #1;
    check("rst_mid_ack_err", {wb_ack, wb_err}, 2'b00);
    check("rst_mid_idle", wb_stall, 1'b0);
    check("rst_mid_errcnt", err_count, 0);
    check("rst_mid_s_cyc", s_cyc, 1'b1);
    exp_errs = 0;
    next_cycle();
    reset = 1'b1; wb_cyc = 1'b0; s_ack = '0;

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 5);
      if (r < NS) begin
        case ($urandom_range(0, 3))
          0:       a = win_base[r];
          1:       a = win_base[r] + 32'h1FC;
          2:       a = win_base[r] + 32'h200;
          default: a = win_base[r] + $urandom_range(0, 511);
        endcase
      end else begin
        a = $urandom;
      end
      do_txn(a, 1'($urandom), $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, TO + 4),
             ($urandom_range(0, 7) == 0) ? $urandom_range(1, TO) : 0,
             1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/leiwand_rv32_wb_intercon.md
# leiwand_rv32_wb_intercon

- Parametrised single-master, N-slave Wishbone (pipelined) interconnect between `leiwand_rv32_core` and the SoC slaves (SRAM, ROM, peripherals).
- Successor to the fixed two-slave stb-decode / OR-combine glue; decode windows are now parameters.
- Tracks the single outstanding request and returns only the selected slave's ack and data.
- Terminates unmapped accesses and unresponsive slaves with a bus error.

## Interface

Parameters:
- `MEM_WIDTH`, 32, address and data width.
- `NUM_SLAVES`, 4, number of slave ports (1..16).
- `SLAVE_BASE`, packed `NUM_SLAVES*MEM_WIDTH`, byte base address of slave k in bits `[k*MEM_WIDTH +: MEM_WIDTH]`; default windows are 0x10000000, 0x20000000, 0x30000000, 0x40000000.
- `SLAVE_SIZE`, packed `NUM_SLAVES*MEM_WIDTH`, byte window size per slave; default is 512 for every slave.
- `TIMEOUT_CYCLES`, 16, maximum number of cycles to wait for a slave ack (at least 1).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wb_stb`, `wb_cyc`, `wb_we` in 1 each: master strobe, cycle and write enable.
- `wb_addr` in `MEM_WIDTH`: master byte address.
- `wb_data_out` in `MEM_WIDTH`: master write data.
- `wb_ack` out 1: master ack.
- `wb_err` out 1: master bus error, pulse.
- `wb_stall` out 1: master stall.
- `wb_data_in` out `MEM_WIDTH`: master read data.
- `s_stb` out `NUM_SLAVES`: per-slave strobe.
- `s_cyc`, `s_we` out 1 each: broadcast cycle and write enable.
- `s_addr` out `MEM_WIDTH`: `wb_addr - SLAVE_BASE[hit]`, a byte offset.
- `s_data_out` out `MEM_WIDTH`: broadcast write data.
- `s_ack`, `s_stall` in `NUM_SLAVES`: per-slave ack and stall.
- `s_data_in` in `NUM_SLAVES*MEM_WIDTH`: per-slave read data.
- `err_count` out 16: saturating count of error terminations.

## Operation

- Decode: slave k is hit when `SLAVE_BASE_k <= wb_addr < SLAVE_BASE_k + SLAVE_SIZE_k`. The comparison is unsigned and computed at `MEM_WIDTH+1` bits so the window end cannot wrap. On overlapping windows the lowest index wins.
- States: IDLE, WAIT, ERR.
- IDLE, request present (`wb_cyc && wb_stb`):
  - Hit on slave k: `s_stb[k]=1`, `wb_stall=s_stall[k]`. When `s_stall[k]=0` the request is accepted: latch `sel=k`, clear the timeout counter, go to WAIT.
  - No hit: `wb_stall=0`, no `s_stb` is driven, request is accepted, go to ERR.
- WAIT:
  - `wb_stall=1` and all `s_stb=0`.
  - `wb_ack=s_ack[sel]` and `wb_data_in=s_data_in[sel]`, both combinational.
  - When `s_ack[sel]=1`, go to IDLE.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`, drive `wb_err=1` for that cycle and go to IDLE.
- ERR: `wb_err=1` for exactly one cycle, `wb_stall=1`, then go to IDLE.
- Every error termination increments `err_count`, which saturates at 0xFFFF.
- `wb_data_in` is 0 whenever `wb_ack=0`.
- `s_ack` from non-selected slaves, and any `s_ack` seen in IDLE or ERR, is ignored.
- `s_cyc=wb_cyc`; `s_we`, `s_data_out` and `s_addr` are combinational pass-throughs.

## Timing

- Reset (`reset=0`, asynchronous): state is IDLE, `sel=0`, counter is 0, `err_count=0`.
  - During reset, `wb_ack=0` and `wb_err=0`.
  - Combinational pass-through outputs follow their inputs throughout.
- Minimum transaction: accept at edge N, then slave ack in cycle N+1 gives `wb_ack` in cycle N+1. The next request can be accepted at edge N+2.
- Unmapped access: accepted at edge N, `wb_err` high in cycle N+1.
- Timeout: with no ack, `wb_err` rises in the `TIMEOUT_CYCLES`-th cycle after accept.
- `s_ack[sel]` and timeout expiry in the same cycle: ack wins, `wb_err=0`, `err_count` unchanged.
- `wb_ack` and `wb_err` are never high together.
- `wb_cyc` deasserted in WAIT or ERR: abort to IDLE on the next edge. No ack or err is issued and `err_count` is unchanged.
- `reset` asserted mid-transaction: immediate return to IDLE; the pending ack is dropped.

## Test plan

- Read slave 0 at 0x10000008, slave returns 0x4A one cycle after accept -> `s_stb=0001`, `s_addr=0x8`, `wb_ack=1` with `wb_data_in=0x4A` for one cycle.
- Write 0x20000004 while slave 1 holds `s_stall[1]=1` for 3 cycles -> `wb_stall=1` for those 3 cycles, accept on cycle 4, then `wb_ack` from slave 1 only.
- Access 0x50000000 (unmapped) -> no `s_stb`, `wb_err=1` in the next cycle, `err_count=1`.
- Slave 2 never acks, `TIMEOUT_CYCLES=16` -> `wb_err=1` in the 16th cycle after accept, then state IDLE. In a second run the ack lands in cycle 16 -> `wb_ack=1` and `wb_err=0`.
- Spurious ack: slave 3 acks during a WAIT on slave 0 -> `wb_ack=0` until `s_ack[0]` arrives.
- Boundary and abort:
  - 0x100001FC hits slave 0; 0x10000200 errors.
  - Drop `wb_cyc` in WAIT -> IDLE with no ack or err.
  - Assert `reset` in WAIT -> IDLE immediately.
